instruction_fetch: RTL and testbench

- Front-end stage that produces the instruction/PC pair consumed by the decode stage.
- Owns the fetch PC and issues in-order read requests to instruction memory through a valid/ready request channel.
- Buffers returned words in a small FIFO and drives the IF/ID output register.
- Honours decode stall and redirects from branch/jump resolution, discarding in-flight responses on redirect.

---
 rtl/instruction_fetch_pkg.sv | 36 +++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instruction_fetch.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared widths, constants and the FIFO entry type for the instruction fetch stage.
// Optional feature macro FETCH_BYPASS_EN is consumed by instruction_fetch.sv.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0013
`endif
`ifndef RESET_VECTOR
`define RESET_VECTOR 32'h0000_0000
`endif
`ifndef PC_STEP
`define PC_STEP 32'd4
`endif

package instruction_fetch_pkg;

    localparam int XLEN = `DATA_WIDTH;
    localparam int ILEN = `INSTRUCTION_WIDTH;

    localparam logic [ILEN-1:0] NOP     = `NOP_INSTRUCTION;
    localparam logic [XLEN-1:0] PC_STEP = `PC_STEP;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched {instruction, pc} pairs.
// Head entry is visible on rdata whenever empty is low.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    input  logic                   clear,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues in-order imem requests under a credit limit and feeds the IF/ID register.
// Define FETCH_BYPASS_EN to let a response load the output register directly when the FIFO is empty.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = `RESET_VECTOR,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic [ILEN-1:0] instruction,
    output logic [XLEN-1:0] pc,
    output logic            valid
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 2;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;

    // PC tags of accepted requests, consumed in order by non-dropped responses
    logic [XLEN-1:0] tag_mem [FIFO_DEPTH];
    logic [AW-1:0]   tag_wr_q, tag_wr_d;
    logic [AW-1:0]   tag_rd_q, tag_rd_d;

    logic            hs, resp_take, bypass;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_wdata, fifo_rdata;

    assign hs        = imem_req_valid && imem_req_ready;
    assign resp_take = imem_resp_valid && (drop_q == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_take && fifo_empty && !stall && !redirect_valid;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push  = resp_take && !redirect_valid && !bypass;
    assign fifo_pop   = !redirect_valid && !stall && !fifo_empty;
    assign fifo_wdata = '{instr: imem_resp_data, pc: tag_mem[tag_rd_q]};

    // Gated by reset so nothing is requested while the stage is held in reset
    assign imem_req_valid = reset && !redirect_valid &&
        ((SW'(outstanding_q) + SW'(fifo_count) + SW'(drop_q)) < SW'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(hs) - CW'(resp_take);
        drop_d        = drop_q - CW'(imem_resp_valid && !resp_take);
        tag_wr_d      = tag_wr_q + AW'(hs);
        tag_rd_d      = tag_rd_q + AW'(resp_take);
        instr_d       = instr_q;
        pc_d          = pc_q;
        valid_d       = valid_q;
        if (hs) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
        if (redirect_valid) begin
            // Every response still in flight must be discarded, including one arriving now
            fetch_pc_d    = align_pc(redirect_pc);
            drop_d        = CW'(SW'(drop_q) + SW'(outstanding_q) - SW'(imem_resp_valid));
            outstanding_d = '0;
            tag_wr_d      = '0;
            tag_rd_d      = '0;
            instr_d       = NOP;
            valid_d       = 1'b0;
        end else if (!stall) begin
            if (fifo_pop) begin
                instr_d = fifo_rdata.instr;
                pc_d    = fifo_rdata.pc;
                valid_d = 1'b1;
            end else if (bypass) begin
                instr_d = imem_resp_data;
                pc_d    = tag_mem[tag_rd_q];
                valid_d = 1'b1;
            end else begin
                instr_d = NOP;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            instr_q       <= NOP;
            pc_q          <= '0;
            valid_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            valid_q       <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            tag_mem[tag_wr_q] <= fetch_pc_q;
        end
    end

    fetch_fifo #(
        .W     (ILEN + XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .clear (redirect_valid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assert property (@(posedge clk) disable iff (!reset) !(fifo_push && fifo_full));

    assign instruction = instr_q;
    assign pc          = pc_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised bench for instruction_fetch against an in-order program-stream model and a queued memory model.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] instruction, pc;
    logic        valid;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .instruction     (instruction),
        .pc              (pc),
        .valid           (valid)
    );

    typedef struct {
        logic [31:0] addr;
        int          acc;
    } mreq_t;

    mreq_t       memq[$];
    int          passed = 0, total = 0, cyc = 0, delivered = 0;
    logic [31:0] m_req_pc, exp_pc;
    logic        pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: drive inputs, check request side, clock, update model, check output register
    task automatic step(input logic rdy, input logic stl, input logic rdr,
                        input logic [31:0] rpc, input logic rsp_ok);
        logic        hs, rv, p_valid;
        logic [31:0] p_instr, p_pc;
        @(negedge clk);
        imem_req_ready = rdy;
        stall          = stl;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        if (rsp_ok && memq.size() > 0 && memq[0].acc <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~memq[0].addr;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
        if (rdr) chk("req_blocked_on_redirect", {31'b0, imem_req_valid}, 32'd0);
        else if (pend) chk("req_held_under_backpressure", {31'b0, imem_req_valid}, 32'd1);
        if (imem_req_valid) chk("req_addr", imem_req_addr, m_req_pc);
        chk("credit_bound", {31'b0, memq.size() <= DEPTH}, 32'd1);
        hs      = imem_req_valid && rdy;
        rv      = imem_resp_valid;
        pend    = imem_req_valid && !rdy && !rdr;
        p_valid = valid;
        p_instr = instruction;
        p_pc    = pc;
        @(posedge clk);
        cyc = cyc + 1;
        if (rv) void'(memq.pop_front());
        if (hs) begin
            memq.push_back('{m_req_pc, cyc});
            m_req_pc = m_req_pc + 32'd4;
        end
        if (rdr) begin
            m_req_pc = rpc & ~32'h3;
            exp_pc   = m_req_pc;
        end
        #1;
        if (rdr) begin
            chk("redirect_valid_low", {31'b0, valid}, 32'd0);
            chk("redirect_nop", instruction, NOP);
        end else if (stl) begin
            chk("stall_hold_valid", {31'b0, valid}, {31'b0, p_valid});
            chk("stall_hold_instr", instruction, p_instr);
            chk("stall_hold_pc", pc, p_pc);
        end else if (valid) begin
            chk("stream_pc", pc, exp_pc);
            chk("stream_instr", instruction, ~exp_pc);
            exp_pc    = exp_pc + 32'd4;
            delivered = delivered + 1;
        end else begin
            chk("empty_nop", instruction, NOP);
        end
    endtask

    logic first_valid_exp [3];

    initial begin
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        stall           = 1'b0;
        m_req_pc        = RPC;
        exp_pc          = RPC;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'b0, valid}, 32'd0);
        chk("reset_instr", instruction, NOP);
        chk("reset_pc", pc, 32'd0);
        chk("reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
        #1 rst_n = 1'b1;

        // Always-ready memory with 1-cycle latency: first valid after edge 3 (edge 2 with bypass)
        first_valid_exp[0] = 1'b0;
`ifdef FETCH_BYPASS_EN
        first_valid_exp[1] = 1'b1;
`else
        first_valid_exp[1] = 1'b0;
`endif
        first_valid_exp[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
            chk($sformatf("first_valid_edge%0d", i + 1), {31'b0, valid}, {31'b0, first_valid_exp[i]});
        end
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

        repeat (4) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("two_outstanding_before_redirect", memq.size(), 32'd2);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

        while (!(memq.size() > 0 && memq[0].acc <= cyc) && cyc < 200)
            step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("response_ready_for_combined", {31'b0, memq.size() > 0}, 32'd1);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0203, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("redirect_aligned_addr", m_req_pc - 32'd4, 32'h0000_0200);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom & 32'h0000_0FFF,
                 $urandom_range(0, 9) < 7);
        end
        chk("liveness", {31'b0, delivered > 200}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
